regfile_wb_arbiter: RTL and testbench

//  Shares the single register-file write port between the in-order pipeline WB stage and
//  the long-latency side unit (mult/div). Pipeline WB has priority. Side results queue in a

---
 rtl/wb_arb_pkg.sv | 18 +
 rtl/regfile_wb_arbiter_if.sv | 31 +++
 rtl/wb_result_fifo.sv | 48 ++++
 rtl/regfile_wb_arbiter.sv | 137 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and default widths for the register-file write-back arbiter.
package wb_arb_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefAddrW = 5;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StForce
  } arb_state_e;

  typedef struct packed {
    logic [DefAddrW-1:0] addr;
    logic [DefDataW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus: pipeline WB request, side-unit result handshake and the regfile write port.
interface regfile_wb_arbiter_if
  import wb_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW
);

  logic              pipe_we;
  logic [ADDR_W-1:0] pipe_addr;
  logic [DATA_W-1:0] pipe_data;
  logic              pipe_stall;
  logic              side_valid;
  logic              side_ready;
  logic [ADDR_W-1:0] side_addr;
  logic [DATA_W-1:0] side_data;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;

  modport master (
    output pipe_we, pipe_addr, pipe_data, side_valid, side_addr, side_data,
    input  pipe_stall, side_ready, rf_we, rf_addr, rf_data
  );

  modport slave (
    input  pipe_we, pipe_addr, pipe_data, side_valid, side_addr, side_data,
    output pipe_stall, side_ready, rf_we, rf_addr, rf_data
  );

endinterface

// File: rtl/wb_result_fifo.sv
// Synchronous FIFO for queued side-unit results; pointers carry an extra wrap bit.
module wb_result_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 37
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [Width-1:0]             wdata,
  input  logic                         pop,
  output logic [Width-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(Depth+1)-1:0]   count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW:0] PtrOne = 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW:0]    wr_q, rd_q;
  logic             do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[PtrW] != rd_q[PtrW]) && (wr_q[PtrW-1:0] == rd_q[PtrW-1:0]);
  assign count   = CntW'(wr_q - rd_q);
  assign rdata   = mem_q[rd_q[PtrW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q[PtrW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PtrOne;
      if (do_pop)  rd_q <= rd_q + PtrOne;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port between pipeline WB (priority) and queued side-unit results,
// with a starvation-forced grant and a pending-destination scoreboard for decode.
module regfile_wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned DATA_W       = DefDataW,
  parameter int unsigned ADDR_W       = DefAddrW,
  parameter int unsigned BUF_DEPTH    = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  regfile_wb_arbiter_if.slave            bus,
  input  logic                           issue_valid,
  input  logic [ADDR_W-1:0]              issue_addr,
  input  logic [ADDR_W-1:0]              rd_addr1,
  input  logic [ADDR_W-1:0]              rd_addr2,
  output logic                           hazard1,
  output logic                           hazard2,
  output logic [$clog2(BUF_DEPTH+1)-1:0] buf_count
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;
  localparam int unsigned CntW    = $clog2(BUF_DEPTH + 1);
  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned EntryW  = ADDR_W + DATA_W;
  localparam logic [CntW-1:0]    CntOne    = 1;
  localparam logic [StarveW-1:0] StarveOne = 1;
  localparam logic [StarveW-1:0] StarveMax = STARVE_LIMIT[StarveW-1:0];

  arb_state_e         state_q, state_d;
  logic [StarveW-1:0] starve_q, starve_d;
  logic [NumRegs-1:0] pending_q, pending_d;

  logic              pipe_req, push, pop, pop_req, last_pop, full, empty;
  logic [EntryW-1:0] head;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              rf_we, stall;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;

  assign pipe_req = bus.pipe_we && (bus.pipe_addr != '0);
  assign push     = bus.side_valid && bus.side_ready;
  assign pop      = pop_req && !empty;
  assign {head_addr, head_data} = head;
  // The head leaving this cycle empties the FIFO unless a new result lands at the same edge.
  assign last_pop = (buf_count == CntOne) && !push;

  wb_result_fifo #(
    .Depth (BUF_DEPTH),
    .Width (EntryW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({bus.side_addr, bus.side_data}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (buf_count)
  );

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    pop_req  = 1'b0;
    stall    = 1'b0;
    rf_we    = pipe_req;
    rf_addr  = bus.pipe_addr;
    rf_data  = bus.pipe_data;
    unique case (state_q)
      StIdle: begin
        if (push) state_d = StWait;
      end
      StWait: begin
        if (pipe_req) begin
          starve_d = starve_q + StarveOne;
          if (starve_d == StarveMax) state_d = StForce;
        end else begin
          pop_req  = 1'b1;
          rf_we    = (head_addr != '0);
          rf_addr  = head_addr;
          rf_data  = head_data;
          starve_d = '0;
          if (last_pop) state_d = StIdle;
        end
      end
      StForce: begin
        stall    = 1'b1;
        pop_req  = 1'b1;
        rf_we    = (head_addr != '0);
        rf_addr  = head_addr;
        rf_data  = head_data;
        starve_d = '0;
        state_d  = last_pop ? StIdle : StWait;
      end
      default: state_d = StIdle;
    endcase
  end

  // Set after clear so a re-issue in the same cycle as the pop keeps the register pending.
  always_comb begin
    pending_d = pending_q;
    if (pop && (head_addr != '0)) pending_d[head_addr] = 1'b0;
    if (issue_valid && (issue_addr != '0)) pending_d[issue_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      starve_q  <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      pending_q <= pending_d;
    end
  end

  assign bus.rf_we      = !rst && rf_we;
  assign bus.rf_addr    = rf_addr;
  assign bus.rf_data    = rf_data;
  assign bus.pipe_stall = !rst && stall;
  assign bus.side_ready = !rst && !full;
  assign hazard1        = !rst && pending_q[rd_addr1];
  assign hazard2        = !rst && pending_q[rd_addr2];

  a_issue_not_pending: assert property (@(posedge clk) disable iff (rst)
    (issue_valid && (issue_addr != '0)) |->
      (!pending_q[issue_addr] || (pop && (head_addr == issue_addr))));

  a_pipe_not_pending: assert property (@(posedge clk) disable iff (rst)
    pipe_req |-> !pending_q[bus.pipe_addr]);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed-vector bench: expected regfile writes go to a scoreboard queue, a negedge monitor
// pops and compares them; per-cycle status outputs are compared inline.
module tb_regfile_wb_arbiter;
  import wb_arb_pkg::*;

  typedef struct packed {
    logic        pw;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        sv;
    logic [4:0]  sa;
    logic [31:0] sd;
    logic        iv;
    logic [4:0]  ia;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        ew;
    logic [4:0]  ea;
    logic [31:0] ed;
    logic        rdy;
    logic        stall;
    logic [1:0]  cnt;
    logic        h1;
    logic        h2;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid;
  logic [4:0] issue_addr, rd_addr1, rd_addr2;
  logic       hazard1, hazard2;
  logic [1:0] buf_count;

  int        total = 0;
  int        bad = 0;
  wb_entry_t exp_q[$];
  wb_entry_t mon_e;
  vec_t      vq[$];

  regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_wb_arbiter #(
    .DATA_W       (32),
    .ADDR_W       (5),
    .BUF_DEPTH    (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .rd_addr1    (rd_addr1),
    .rd_addr2    (rd_addr2),
    .hazard1     (hazard1),
    .hazard2     (hazard2),
    .buf_count   (buf_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  function automatic vec_t v(int pw, int pa, int pd, int sv, int sa, int sd, int iv, int ia,
                             int r1, int r2, int ew, int ea, int ed, int rdy, int stall,
                             int cnt, int h1, int h2);
    vec_t r;
    r.pw = 1'(pw);   r.pa = 5'(pa);   r.pd = 32'(pd);
    r.sv = 1'(sv);   r.sa = 5'(sa);   r.sd = 32'(sd);
    r.iv = 1'(iv);   r.ia = 5'(ia);   r.r1 = 5'(r1);   r.r2 = 5'(r2);
    r.ew = 1'(ew);   r.ea = 5'(ea);   r.ed = 32'(ed);
    r.rdy = 1'(rdy); r.stall = 1'(stall); r.cnt = 2'(cnt); r.h1 = 1'(h1); r.h2 = 1'(h2);
    return r;
  endfunction

  task automatic apply(input vec_t x, input int idx);
    wb_entry_t e;
    bus.pipe_we    = x.pw;
    bus.pipe_addr  = x.pa;
    bus.pipe_data  = x.pd;
    bus.side_valid = x.sv;
    bus.side_addr  = x.sa;
    bus.side_data  = x.sd;
    issue_valid    = x.iv;
    issue_addr     = x.ia;
    rd_addr1       = x.r1;
    rd_addr2       = x.r2;
    #1;
    if (x.ew) begin
      e.addr = x.ea;
      e.data = x.ed;
      exp_q.push_back(e);
    end
    chk($sformatf("v%0d rf_we", idx), bus.rf_we, x.ew);
    chk($sformatf("v%0d side_ready", idx), bus.side_ready, x.rdy);
    chk($sformatf("v%0d pipe_stall", idx), bus.pipe_stall, x.stall);
    chk($sformatf("v%0d buf_count", idx), buf_count, x.cnt);
    chk($sformatf("v%0d hazard1", idx), hazard1, x.h1);
    chk($sformatf("v%0d hazard2", idx), hazard2, x.h2);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every regfile write outside reset must match the next expected entry.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rf_write unexpected: got r%0d=%0h expected no write",
                 bus.rf_addr, bus.rf_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rf_addr", 32'(bus.rf_addr), 32'(mon_e.addr));
        chk("rf_data", bus.rf_data, mon_e.data);
      end
    end
  end

  initial begin
    // Reset with live requests on every input: nothing may leak out.
    rst = 1'b1;
    bus.pipe_we = 1'b1; bus.pipe_addr = 5'd4; bus.pipe_data = 32'h44;
    bus.side_valid = 1'b1; bus.side_addr = 5'd6; bus.side_data = 32'h66;
    issue_valid = 1'b1; issue_addr = 5'd2; rd_addr1 = 5'd2; rd_addr2 = 5'd0;
    @(posedge clk); #1;
    chk("rst rf_we", bus.rf_we, 0);
    chk("rst side_ready", bus.side_ready, 0);
    chk("rst pipe_stall", bus.pipe_stall, 0);
    chk("rst buf_count", buf_count, 0);
    @(posedge clk); #1;
    chk("rst2 rf_we", bus.rf_we, 0);
    chk("rst2 side_ready", bus.side_ready, 0);
    chk("rst2 hazard1", hazard1, 0);
    rst = 1'b0;

    // pw pa pd  sv sa sd  iv ia  r1 r2  ew ea ed  rdy stall cnt h1 h2
    vq.push_back(v(0, 0, 0, 1, 6, 'h66, 0, 0, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 'h66, 1, 0, 1, 0, 0));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    // Idle side result with hazard release
    vq.push_back(v(0, 0, 0, 0, 0, 0, 1, 5, 5, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    vq.push_back(v(0, 0, 0, 1, 5, 'hA5, 0, 0, 5, 0, 0, 0, 0, 1, 0, 0, 1, 0));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 1, 5, 'hA5, 1, 0, 1, 1, 0));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    // Priority then forced grant after four pipe grants in WAIT
    vq.push_back(v(1, 3, 'h30, 1, 7, 'h77, 0, 0, 0, 0, 1, 3, 'h30, 1, 0, 0, 0, 0));
    vq.push_back(v(1, 3, 'h31, 0, 0, 0, 0, 0, 0, 0, 1, 3, 'h31, 1, 0, 1, 0, 0));
    vq.push_back(v(1, 3, 'h32, 0, 0, 0, 0, 0, 0, 0, 1, 3, 'h32, 1, 0, 1, 0, 0));
    vq.push_back(v(1, 3, 'h33, 0, 0, 0, 0, 0, 0, 0, 1, 3, 'h33, 1, 0, 1, 0, 0));
    vq.push_back(v(1, 3, 'h34, 0, 0, 0, 0, 0, 0, 0, 1, 3, 'h34, 1, 0, 1, 0, 0));
    vq.push_back(v(1, 3, 'h35, 0, 0, 0, 0, 0, 0, 0, 1, 7, 'h77, 1, 1, 1, 0, 0));
    vq.push_back(v(1, 3, 'h35, 0, 0, 0, 0, 0, 0, 0, 1, 3, 'h35, 1, 0, 0, 0, 0));
    // Full FIFO: third result waits on the bus
    vq.push_back(v(1, 3, 'h50, 1, 10, 'hA1, 0, 0, 0, 0, 1, 3, 'h50, 1, 0, 0, 0, 0));
    vq.push_back(v(1, 3, 'h51, 1, 11, 'hA2, 0, 0, 0, 0, 1, 3, 'h51, 1, 0, 1, 0, 0));
    vq.push_back(v(1, 3, 'h52, 1, 12, 'hA3, 0, 0, 0, 0, 1, 3, 'h52, 0, 0, 2, 0, 0));
    vq.push_back(v(1, 3, 'h53, 1, 12, 'hA3, 0, 0, 0, 0, 1, 3, 'h53, 0, 0, 2, 0, 0));
    vq.push_back(v(1, 3, 'h54, 1, 12, 'hA3, 0, 0, 0, 0, 1, 3, 'h54, 0, 0, 2, 0, 0));
    vq.push_back(v(1, 3, 'h55, 1, 12, 'hA3, 0, 0, 0, 0, 1, 10, 'hA1, 0, 1, 2, 0, 0));
    vq.push_back(v(1, 3, 'h55, 1, 12, 'hA3, 0, 0, 0, 0, 1, 3, 'h55, 1, 0, 1, 0, 0));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 11, 'hA2, 0, 0, 2, 0, 0));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 'hA3, 1, 0, 1, 0, 0));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    // Scoreboard: re-issue on the pop cycle keeps r9 pending
    vq.push_back(v(0, 0, 0, 0, 0, 0, 1, 9, 9, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    vq.push_back(v(0, 0, 0, 1, 9, 'h99, 0, 0, 9, 0, 0, 0, 0, 1, 0, 0, 1, 0));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 1, 9, 9, 0, 1, 9, 'h99, 1, 0, 1, 1, 0));
    vq.push_back(v(0, 0, 0, 1, 9, 'h9A, 0, 0, 9, 9, 0, 0, 0, 1, 0, 0, 1, 1));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 9, 9, 1, 9, 'h9A, 1, 0, 1, 1, 1));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 9, 9, 0, 0, 0, 1, 0, 0, 0, 0));
    // Register zero: no pipe grant, side entry popped silently, r8 stays pending
    vq.push_back(v(1, 0, 'hDEAD, 0, 0, 0, 1, 8, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    vq.push_back(v(0, 0, 0, 1, 0, 'h11, 0, 0, 8, 0, 0, 0, 0, 1, 0, 0, 1, 0));
    vq.push_back(v(1, 0, 'hDEAD, 0, 0, 0, 0, 0, 8, 0, 0, 0, 0, 1, 0, 1, 1, 0));
    vq.push_back(v(0, 0, 0, 1, 8, 'h88, 0, 0, 8, 0, 0, 0, 0, 1, 0, 0, 1, 0));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 8, 0, 1, 8, 'h88, 1, 0, 1, 1, 0));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 8, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    // Queue one result, then reset before it can be written
    vq.push_back(v(0, 0, 0, 1, 13, 'h0D, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));

    foreach (vq[i]) apply(vq[i], i);

    bus.side_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst rf_we", bus.rf_we, 0);
    chk("midrst pipe_stall", bus.pipe_stall, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("postrst buf_count", buf_count, 0);
    chk("postrst rf_we", bus.rf_we, 0);
    @(posedge clk); #1;
    chk("postrst2 rf_we", bus.rf_we, 0);

    @(posedge clk); #1;
    chk("scoreboard drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
